ram8_bank: RTL
==============

Name: ram8_bank

Overview:
- Eight-word register bank; the storage stage directly downstream of the 8-way load demultiplexer.
- One write port:
  - `load` is steered to exactly one word by `address`, decoded 8-way.
  - Decode order: outputs a..h map to words 0..7; `address[2]` is the MSB.
- One registered read port with a valid strobe.
- Per-word "written" flags.
- Building block for the RAM64 and RAM512 hierarchy.

Parameters:
- WIDTH, 16, data word width in bits.

Ports:
- clk  input  1  rising-edge clock, the single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  write data.
- address  input  3  write word select (0..7).
- load  input  1  write enable; sampled at the rising edge of clk.
- rd_en  input  1  read request.
- rd_addr  input  3  read word select (0..7).
- out  output  WIDTH  registered read data.
- out_valid  output  1  one-cycle strobe: `out` was updated this cycle.
- written  output  8  sticky per-word flag; bit i set once word i has been written.

Behaviour:
- Reset (rst_n=0), asynchronous, takes effect immediately regardless of clk:
  - all 8 words = 0.
  - out = 0, out_valid = 0, written = 8'h00.
  - Applies mid-operation too: a write or read in flight in the same cycle is discarded.
- Deassertion of rst_n is honoured at the next rising edge.
- Write:
  - At a rising edge with load=1, word[address] <= in.
  - All other words hold their value.
  - written[address] <= 1.
  - load=0: no word changes, including when `address` toggles.
- Write decode: `load` is demultiplexed 8-way by `address`, so exactly one word enable is high when load=1 and none when load=0.
- Read:
  - At a rising edge with rd_en=1: out <= word[rd_addr] and out_valid <= 1.
  - Latency is 1 cycle from request to data.
  - rd_en=0: out holds its last value and out_valid <= 0.
  - Back-to-back reads are permitted: one read per cycle with full throughput.
- Written flags:
  - Set-only; cleared only by reset.
  - Re-writing a word leaves its flag at 1.
- Simultaneous write and read, different addresses: independent; the read returns the stored value.
- Simultaneous write and read, same address: see the Optional Feature.
- Out-of-range addresses: none exist (3-bit address), so no guard is needed.
- No handshake back-pressure: the bank always accepts load and rd_en.

Optional Feature:
- Macro: RAM8_BYPASS_EN.
- Defined: when load=1, rd_en=1 and address==rd_addr in the same cycle, out <= in (write-through forwarding).
- Not defined: in the same case, out <= the old word[rd_addr] (read-before-write); the new data is visible to a read in the following cycle.
- Storage and written-flag behaviour are identical in both builds.

Test Plan:
- Reset check: hold rst_n=0 → out=0, out_valid=0, written=8'h00. Release rst_n, then read addresses 0..7 → every out=0, out_valid=1 on each cycle after a read.
- Walking write: for a = 0..7, write in=16'h1111*(a+1) to address a, then read 0..7.
  - out = 16'h1111, 16'h2222, ... 16'h8888, each one cycle after its request.
  - written = 8'hFF after the writes.
- Decode isolation: write 16'hBEEF to address 5 with load=1, then toggle address through 0..7 with load=0 and in=16'hFFFF. Read all words → only word 5 = 16'hBEEF; written = 8'h20.
- Same-address collision: word 3 = 16'h00AA; in one cycle write 16'h0055 to address 3 with rd_en=1, rd_addr=3.
  - Without macro: out=16'h00AA.
  - With RAM8_BYPASS_EN: out=16'h0055.
  - In both builds, the next read of address 3 returns 16'h0055.
- Read hold: read address 7 (value 16'h8888), then keep rd_en=0 for 3 cycles → out stays 16'h8888 and out_valid=0 on those cycles.
- Async reset mid-operation: with written=8'hFF, assert rst_n=0 between clock edges → out, written and all words clear immediately, without waiting for a clock edge. A subsequent read of address 2 returns 0.

Source files
------------

// File: rtl/ram8_bank.sv
// Eight-word register bank: 8-way decoded write port, registered read port with valid strobe,
// sticky per-word written flags. Define RAM8_BYPASS_EN for same-address write-through forwarding.
module ram8_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       address,
  input  logic             load,
  input  logic             rd_en,
  input  logic [2:0]       rd_addr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [7:0]       written
);

  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];
  logic [7:0]       written_q, written_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       word_we;

  // Valid semantics: out_valid is high for exactly the one cycle after a rd_en request and
  // marks that out was refreshed; there is no ready, the bank accepts every load and rd_en.
  always_comb begin
    word_we = 8'h00;
    if (load) word_we[address] = 1'b1;

    for (int i = 0; i < 8; i++) begin
      mem_d[i] = word_we[i] ? in : mem_q[i];
    end
    written_d = written_q | word_we;

    out_d       = out_q;
    out_valid_d = 1'b0;
    if (rd_en) begin
      out_valid_d = 1'b1;
`ifdef RAM8_BYPASS_EN
      out_d = (load && (address == rd_addr)) ? in : mem_q[rd_addr];
`else
      // Read-before-write: a same-cycle write is seen by the next read.
      out_d = mem_q[rd_addr];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= '0;
      end
      written_q   <= 8'h00;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= mem_d[i];
      end
      written_q   <= written_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign written   = written_q;

endmodule
